// File: rtl/gpu_wb_slave_bridge_if.sv
// Wishbone slave-side bus bundle for the GPU register bridge.
// Signal names follow the bridge port naming (inputs _i, outputs _o as seen by the slave).
interface gpu_wb_slave_bridge_if #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [SEL_W-1:0]  wb_sel_i;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/gpu_wb_slave_bridge.sv
// Wishbone slave front-end for the GPU: region decode, wait states, busy stall with
// timeout, read-back with fixed latency and error termination for unmapped addresses.
module gpu_wb_slave_bridge #(
    parameter int unsigned ADDR_W       = 27,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NUM_REGIONS  = 4,
    parameter int unsigned REGION_LSB   = 12,
    parameter int unsigned REGION_BITS  = 4,
    parameter int unsigned CATCH_ALL    = 1,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned TIMEOUT      = 15,
    localparam int unsigned SEL_W       = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          reset,
    gpu_wb_slave_bridge_if.slave          wb,
    output logic [NUM_REGIONS-1:0]        o_reg_we,
    output logic [NUM_REGIONS-1:0]        o_reg_re,
    output logic [ADDR_W-1:0]             o_reg_addr,
    output logic [DATA_W-1:0]             o_reg_wdata,
    output logic [SEL_W-1:0]              o_reg_sel,
    input  logic [NUM_REGIONS*DATA_W-1:0] i_reg_rdata,
    input  logic [NUM_REGIONS-1:0]        i_region_busy
);
    localparam int unsigned RIDX_W  = $clog2(NUM_REGIONS);
    localparam int unsigned WCNT_W  = 4;
    localparam int unsigned RCNT_W  = 4;
    localparam int unsigned STALL_W = 8;

    // STROBE is the cycle the one-hot strobe is visible; ACK/ERR coincide with wb_ack_o/wb_err_o.
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ISSUE, S_STROBE, S_RDWAIT, S_ACK, S_ERR
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      adr_q, adr_d;
    logic [DATA_W-1:0]      wdat_q, wdat_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   wr_q, wr_d;
    logic [RIDX_W-1:0]      ridx_q, ridx_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
    logic [STALL_W-1:0]     stall_q, stall_d;
    logic                   silent_q, silent_d;
    logic [DATA_W-1:0]      dat_q, dat_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [NUM_REGIONS-1:0] we_q, we_d;
    logic [NUM_REGIONS-1:0] re_q, re_d;

    logic [REGION_BITS-1:0] dec_field;
    logic [RIDX_W-1:0]      dec_ridx;
    logic                   dec_mapped;
    logic                   busy_sel;
    logic [DATA_W-1:0]      rdata_sel;
    logic [NUM_REGIONS-1:0] region_onehot;
    logic                   req;

    assign dec_field = wb.wb_adr_i[REGION_LSB +: REGION_BITS];
    assign req       = wb.wb_cyc_i & wb.wb_stb_i;

    // Region decode of the live bus address, clamped or flagged per CATCH_ALL.
    always_comb begin
        dec_ridx   = '0;
        dec_mapped = 1'b1;
        if (CATCH_ALL != 0) begin
            if (32'(dec_field) >= NUM_REGIONS - 1) dec_ridx = RIDX_W'(NUM_REGIONS - 1);
            else                                   dec_ridx = RIDX_W'(dec_field);
        end else begin
            if (32'(dec_field) >= NUM_REGIONS) dec_mapped = 1'b0;
            else                               dec_ridx   = RIDX_W'(dec_field);
        end
    end

    // Per-region selection using the latched region index.
    always_comb begin
        busy_sel      = 1'b0;
        rdata_sel     = '0;
        region_onehot = '0;
        for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
            if (ridx_q == RIDX_W'(r)) begin
                busy_sel         = i_region_busy[r];
                rdata_sel        = i_reg_rdata[r*DATA_W +: DATA_W];
                region_onehot[r] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        sel_d    = sel_q;
        wr_d     = wr_q;
        ridx_d   = ridx_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        stall_d  = stall_q;
        silent_d = silent_q;
        dat_d    = dat_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    adr_d    = wb.wb_adr_i;
                    wdat_d   = wb.wb_dat_i;
                    sel_d    = wb.wb_sel_i;
                    wr_d     = wb.wb_we_i;
                    ridx_d   = dec_ridx;
                    wcnt_d   = '0;
                    rcnt_d   = '0;
                    stall_d  = '0;
                    silent_d = 1'b0;
                    if (!dec_mapped)           state_d = S_ERR;
                    else if (WAIT_CYCLES != 0) state_d = S_WAIT;
                    else                       state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (!wb.wb_cyc_i)                               state_d = S_IDLE;
                else if (wcnt_q == WCNT_W'(WAIT_CYCLES - 1))    state_d = S_ISSUE;
                else                                            wcnt_d  = wcnt_q + WCNT_W'(1);
            end
            S_ISSUE: begin
                if (!wb.wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (busy_sel) begin
                    if (stall_q == STALL_W'(TIMEOUT - 1)) state_d = S_ERR;
                    else                                  stall_d = stall_q + STALL_W'(1);
                end else begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                // A read already strobed must run its latency out even if the master leaves.
                if (wr_q) begin
                    state_d = wb.wb_cyc_i ? S_ACK : S_IDLE;
                end else begin
                    silent_d = silent_q | ~wb.wb_cyc_i;
                    rcnt_d   = '0;
                    state_d  = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                silent_d = silent_q | ~wb.wb_cyc_i;
                if (rcnt_q == RCNT_W'(READ_LATENCY - 1)) begin
                    if (silent_q || !wb.wb_cyc_i) begin
                        state_d = S_IDLE;
                    end else begin
                        dat_d   = rdata_sel;
                        state_d = S_ACK;
                    end
                end else begin
                    rcnt_d = rcnt_q + RCNT_W'(1);
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are registered versions of the state being entered.
        ack_d = (state_d == S_ACK);
        err_d = (state_d == S_ERR);
        we_d  = ((state_d == S_STROBE) &&  wr_q) ? region_onehot : '0;
        re_d  = ((state_d == S_STROBE) && !wr_q) ? region_onehot : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            wdat_q   <= '0;
            sel_q    <= '0;
            wr_q     <= 1'b0;
            ridx_q   <= '0;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            stall_q  <= '0;
            silent_q <= 1'b0;
            dat_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= '0;
            re_q     <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            sel_q    <= sel_d;
            wr_q     <= wr_d;
            ridx_q   <= ridx_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            stall_q  <= stall_d;
            silent_q <= silent_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            we_q     <= we_d;
            re_q     <= re_d;
        end
    end

    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign o_reg_we    = we_q;
    assign o_reg_re    = re_q;
    assign o_reg_addr  = adr_q;
    assign o_reg_wdata = wdat_q;
    assign o_reg_sel   = sel_q;
endmodule

// File: tb/tb_gpu_wb_slave_bridge.sv
// Directed bench for gpu_wb_slave_bridge: a catch-all instance (READ_LATENCY=2) and a
// strict-decode instance, cycle numbers counted from the edge that samples the request.
module tb_gpu_wb_slave_bridge;
    localparam int unsigned AW = 27;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned NR = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gpu_wb_slave_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    gpu_wb_slave_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    logic [NR-1:0]    we0, re0, busy0, we1, re1, busy1;
    logic [AW-1:0]    addr0, addr1;
    logic [DW-1:0]    wdata0, wdata1;
    logic [SW-1:0]    sel0, sel1;
    logic [NR*DW-1:0] rdata0, rdata1;

    gpu_wb_slave_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGIONS(NR), .REGION_LSB(12), .REGION_BITS(4),
        .CATCH_ALL(1), .WAIT_CYCLES(1), .READ_LATENCY(2), .TIMEOUT(15)
    ) dut0 (
        .clk(clk), .reset(reset), .wb(bus0),
        .o_reg_we(we0), .o_reg_re(re0), .o_reg_addr(addr0), .o_reg_wdata(wdata0),
        .o_reg_sel(sel0), .i_reg_rdata(rdata0), .i_region_busy(busy0)
    );

    gpu_wb_slave_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGIONS(NR), .REGION_LSB(12), .REGION_BITS(4),
        .CATCH_ALL(0), .WAIT_CYCLES(1), .READ_LATENCY(1), .TIMEOUT(15)
    ) dut1 (
        .clk(clk), .reset(reset), .wb(bus1),
        .o_reg_we(we1), .o_reg_re(re1), .o_reg_addr(addr1), .o_reg_wdata(wdata1),
        .o_reg_sel(sel1), .i_reg_rdata(rdata1), .i_region_busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    logic [NR-1:0] we_log  [0:23];
    logic [NR-1:0] re_log  [0:23];
    logic          ack_log [0:23];
    logic          err_log [0:23];
    logic [DW-1:0] dat_log [0:23];
    logic [DW-1:0] wd_log  [0:23];
    logic [SW-1:0] sel_log [0:23];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_idle();
        for (int r = 0; r < int'(NR); r++) rdata0[r*DW +: DW] = 32'hBAD0_0000 + 32'(r);
    endtask

    task automatic start(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel);
        bus0.wb_cyc_i = 1'b1;
        bus0.wb_stb_i = 1'b1;
        bus0.wb_we_i  = we;
        bus0.wb_adr_i = adr;
        bus0.wb_dat_i = dat;
        bus0.wb_sel_i = sel;
    endtask

    // Records dut0 outputs cycle by cycle while acting as a classic Wishbone master.
    task automatic capture(input int n, input int rd_cyc, input int rd_reg, input logic [DW-1:0] rd_val,
                           input int busy_rel, input int abort_cyc);
        for (int c = 0; c < n; c++) begin
            tick();
            we_log[c]  = we0;
            re_log[c]  = re0;
            ack_log[c] = bus0.wb_ack_o;
            err_log[c] = bus0.wb_err_o;
            dat_log[c] = bus0.wb_dat_o;
            wd_log[c]  = wdata0;
            sel_log[c] = sel0;
            if (bus0.wb_ack_o || bus0.wb_err_o || c == abort_cyc) begin
                bus0.wb_cyc_i = 1'b0;
                bus0.wb_stb_i = 1'b0;
            end
            if (c == busy_rel) busy0 = '0;
            rd_idle();
            if (c == rd_cyc) rdata0[rd_reg*DW +: DW] = rd_val;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0; bus0.wb_we_i = 1'b0;
        bus0.wb_adr_i = '0;   bus0.wb_dat_i = '0;   bus0.wb_sel_i = '0;
        bus1.wb_cyc_i = 1'b0; bus1.wb_stb_i = 1'b0; bus1.wb_we_i = 1'b0;
        bus1.wb_adr_i = '0;   bus1.wb_dat_i = '0;   bus1.wb_sel_i = '0;
        busy0 = '0; busy1 = '0; rdata1 = '0;
        rd_idle();
        repeat (2) tick();
        checks++; if ({we0, re0} !== 8'h00) begin errors++; $display("FAIL reset_strobes got %h expected 00", {we0, re0}); end
        checks++; if ({bus0.wb_ack_o, bus0.wb_err_o} !== 2'b00) begin errors++; $display("FAIL reset_ackerr got %b expected 00", {bus0.wb_ack_o, bus0.wb_err_o}); end
        checks++; if (bus0.wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h expected 0", bus0.wb_dat_o); end
        checks++; if ({addr0, wdata0, sel0} !== '0) begin errors++; $display("FAIL reset_latches got %h/%h/%h expected 0", addr0, wdata0, sel0); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        logic [NR-1:0] exp_we;
        start(1'b1, 27'h01004, 32'hDEADBEEF, 4'hF);
        capture(6, -1, 0, 32'h0, -1, -1);
        for (int c = 0; c < 6; c++) begin
            exp_we = (c == 2) ? 4'b0010 : 4'b0000;
            checks++; if (we_log[c] !== exp_we) begin errors++; $display("FAIL write_we cycle %0d got %b expected %b", c, we_log[c], exp_we); end
            checks++; if (ack_log[c] !== (c == 3)) begin errors++; $display("FAIL write_ack cycle %0d got %b expected %b", c, ack_log[c], c == 3); end
            checks++; if ((re_log[c] !== 4'b0) || (err_log[c] !== 1'b0)) begin errors++; $display("FAIL write_re_err cycle %0d got %b/%b expected 0000/0", c, re_log[c], err_log[c]); end
        end
        checks++; if (wd_log[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_wdata got %h expected DEADBEEF", wd_log[2]); end
        checks++; if (sel_log[2] !== 4'hF) begin errors++; $display("FAIL write_sel got %h expected F", sel_log[2]); end
        checks++; if (dat_log[5] !== 32'h0) begin errors++; $display("FAIL write_dat_untouched got %h expected 0", dat_log[5]); end
    endtask

    task automatic test_read();
        logic [NR-1:0] exp_re;
        start(1'b0, 27'h03000, 32'h0, 4'hF);
        capture(8, 4, 3, 32'h12345678, -1, -1);
        for (int c = 0; c < 8; c++) begin
            exp_re = (c == 2) ? 4'b1000 : 4'b0000;
            checks++; if (re_log[c] !== exp_re) begin errors++; $display("FAIL read_re cycle %0d got %b expected %b", c, re_log[c], exp_re); end
            checks++; if (ack_log[c] !== (c == 5)) begin errors++; $display("FAIL read_ack cycle %0d got %b expected %b", c, ack_log[c], c == 5); end
            checks++; if (we_log[c] !== 4'b0) begin errors++; $display("FAIL read_we cycle %0d got %b expected 0000", c, we_log[c]); end
        end
        checks++; if (dat_log[4] !== 32'h0) begin errors++; $display("FAIL read_dat_early got %h expected 0", dat_log[4]); end
        checks++; if (dat_log[5] !== 32'h12345678) begin errors++; $display("FAIL read_dat got %h expected 12345678", dat_log[5]); end
        checks++; if (dat_log[7] !== 32'h12345678) begin errors++; $display("FAIL read_dat_hold got %h expected 12345678", dat_log[7]); end
    endtask

    task automatic test_catch_all();
        logic [NR-1:0] exp_we;
        start(1'b1, 27'h0F000, 32'h0000_00A5, 4'h1);
        capture(6, -1, 0, 32'h0, -1, -1);
        for (int c = 0; c < 6; c++) begin
            exp_we = (c == 2) ? 4'b1000 : 4'b0000;
            checks++; if (we_log[c] !== exp_we) begin errors++; $display("FAIL catchall_we cycle %0d got %b expected %b", c, we_log[c], exp_we); end
            checks++; if ((ack_log[c] !== (c == 3)) || (err_log[c] !== 1'b0)) begin errors++; $display("FAIL catchall_ackerr cycle %0d got %b/%b expected %b/0", c, ack_log[c], err_log[c], c == 3); end
        end
        checks++; if (sel_log[2] !== 4'h1) begin errors++; $display("FAIL catchall_sel got %h expected 1", sel_log[2]); end
    endtask

    task automatic test_unmapped();
        logic [NR-1:0] exp_we;
        bus1.wb_cyc_i = 1'b1; bus1.wb_stb_i = 1'b1; bus1.wb_we_i = 1'b1;
        bus1.wb_adr_i = 27'h05000; bus1.wb_dat_i = 32'h0BAD0BAD; bus1.wb_sel_i = 4'hF;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (bus1.wb_err_o !== (c == 0)) begin errors++; $display("FAIL unmapped_err cycle %0d got %b expected %b", c, bus1.wb_err_o, c == 0); end
            checks++; if ({we1, re1, bus1.wb_ack_o} !== 9'h0) begin errors++; $display("FAIL unmapped_quiet cycle %0d got %b expected 0", c, {we1, re1, bus1.wb_ack_o}); end
            if (c == 0) begin
                checks++; if (addr1 !== 27'h05000) begin errors++; $display("FAIL unmapped_addr got %h expected 05000", addr1); end
            end
            if (bus1.wb_err_o) begin bus1.wb_cyc_i = 1'b0; bus1.wb_stb_i = 1'b0; end
        end
        // Highest legal field value still decodes on the strict instance.
        bus1.wb_cyc_i = 1'b1; bus1.wb_stb_i = 1'b1; bus1.wb_we_i = 1'b1;
        bus1.wb_adr_i = 27'h03000; bus1.wb_dat_i = 32'h600DF00D; bus1.wb_sel_i = 4'h0;
        for (int c = 0; c < 6; c++) begin
            tick();
            exp_we = (c == 2) ? 4'b1000 : 4'b0000;
            checks++; if (we1 !== exp_we) begin errors++; $display("FAIL strict_we cycle %0d got %b expected %b", c, we1, exp_we); end
            checks++; if ((bus1.wb_ack_o !== (c == 3)) || (bus1.wb_err_o !== 1'b0)) begin errors++; $display("FAIL strict_ackerr cycle %0d got %b/%b expected %b/0", c, bus1.wb_ack_o, bus1.wb_err_o, c == 3); end
            if (c == 2) begin
                checks++; if ({wdata1, sel1, re1} !== {32'h600DF00D, 4'h0, 4'h0}) begin errors++; $display("FAIL strict_payload got %h/%h/%b expected 600DF00D/0/0000", wdata1, sel1, re1); end
            end
            if (bus1.wb_ack_o) begin bus1.wb_cyc_i = 1'b0; bus1.wb_stb_i = 1'b0; end
        end
    endtask

    task automatic test_timeout();
        busy0 = 4'b0100;
        start(1'b1, 27'h02000, 32'h11112222, 4'hF);
        capture(20, -1, 0, 32'h0, -1, -1);
        for (int c = 0; c < 20; c++) begin
            checks++; if (err_log[c] !== (c == 16)) begin errors++; $display("FAIL timeout_err cycle %0d got %b expected %b", c, err_log[c], c == 16); end
            checks++; if ({we_log[c], re_log[c], ack_log[c]} !== 9'h0) begin errors++; $display("FAIL timeout_quiet cycle %0d got %b expected 0", c, {we_log[c], re_log[c], ack_log[c]}); end
        end
        busy0 = '0;
    endtask

    task automatic test_busy_release();
        logic [NR-1:0] exp_we;
        busy0 = 4'b0100;
        start(1'b1, 27'h02000, 32'h33334444, 4'hC);
        capture(10, -1, 0, 32'h0, 4, -1);
        for (int c = 0; c < 10; c++) begin
            exp_we = (c == 5) ? 4'b0100 : 4'b0000;
            checks++; if (we_log[c] !== exp_we) begin errors++; $display("FAIL release_we cycle %0d got %b expected %b", c, we_log[c], exp_we); end
            checks++; if ((ack_log[c] !== (c == 6)) || (err_log[c] !== 1'b0)) begin errors++; $display("FAIL release_ackerr cycle %0d got %b/%b expected %b/0", c, ack_log[c], err_log[c], c == 6); end
        end
        checks++; if (wd_log[5] !== 32'h33334444) begin errors++; $display("FAIL release_wdata got %h expected 33334444", wd_log[5]); end
    endtask

    task automatic test_abort();
        logic [NR-1:0] exp_we;
        start(1'b1, 27'h01008, 32'h77778888, 4'hF);
        capture(6, -1, 0, 32'h0, -1, 0);
        for (int c = 0; c < 6; c++) begin
            checks++; if ({we_log[c], re_log[c], ack_log[c], err_log[c]} !== 10'h0) begin errors++; $display("FAIL abort_quiet cycle %0d got %b expected 0", c, {we_log[c], re_log[c], ack_log[c], err_log[c]}); end
        end
        start(1'b1, 27'h01010, 32'h55AA55AA, 4'h3);
        capture(6, -1, 0, 32'h0, -1, -1);
        for (int c = 0; c < 6; c++) begin
            exp_we = (c == 2) ? 4'b0010 : 4'b0000;
            checks++; if (we_log[c] !== exp_we) begin errors++; $display("FAIL abort_next_we cycle %0d got %b expected %b", c, we_log[c], exp_we); end
            checks++; if (ack_log[c] !== (c == 3)) begin errors++; $display("FAIL abort_next_ack cycle %0d got %b expected %b", c, ack_log[c], c == 3); end
        end
    endtask

    task automatic test_reset_rdwait();
        start(1'b0, 27'h00010, 32'h0, 4'hF);
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 2) begin
                checks++; if (re0 !== 4'b0001) begin errors++; $display("FAIL rstrd_re got %b expected 0001", re0); end
            end
        end
        reset = 1'b1;
        #1;
        checks++; if ({we0, re0, bus0.wb_ack_o, bus0.wb_err_o} !== 10'h0) begin errors++; $display("FAIL rstrd_outputs got %b expected 0", {we0, re0, bus0.wb_ack_o, bus0.wb_err_o}); end
        checks++; if (bus0.wb_dat_o !== 32'h0) begin errors++; $display("FAIL rstrd_dat got %h expected 0", bus0.wb_dat_o); end
        checks++; if (addr0 !== 27'h0) begin errors++; $display("FAIL rstrd_addr got %h expected 0", addr0); end
        bus0.wb_cyc_i = 1'b0;
        bus0.wb_stb_i = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        capture(8, -1, 0, 32'h0, -1, -1);
        for (int c = 0; c < 8; c++) begin
            checks++; if ({we_log[c], re_log[c], ack_log[c], err_log[c]} !== 10'h0) begin errors++; $display("FAIL rstrd_after cycle %0d got %b expected 0", c, {we_log[c], re_log[c], ack_log[c], err_log[c]}); end
        end
        checks++; if (dat_log[7] !== 32'h0) begin errors++; $display("FAIL rstrd_dat_after got %h expected 0", dat_log[7]); end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] exp_we;
        start(1'b1, 27'h01000, 32'hAAAA0001, 4'hF);
        for (int c = 0; c < 12; c++) begin
            tick();
            we_log[c]  = we0;
            ack_log[c] = bus0.wb_ack_o;
            wd_log[c]  = wdata0;
            if (c == 4) begin
                bus0.wb_adr_i = 27'h02000;
                bus0.wb_dat_i = 32'hBBBB0002;
            end
            if (c == 8) begin
                bus0.wb_cyc_i = 1'b0;
                bus0.wb_stb_i = 1'b0;
            end
        end
        for (int c = 0; c < 12; c++) begin
            exp_we = (c == 2) ? 4'b0010 : ((c == 7) ? 4'b0100 : 4'b0000);
            checks++; if (we_log[c] !== exp_we) begin errors++; $display("FAIL b2b_we cycle %0d got %b expected %b", c, we_log[c], exp_we); end
            checks++; if (ack_log[c] !== (c == 3 || c == 8)) begin errors++; $display("FAIL b2b_ack cycle %0d got %b expected %b", c, ack_log[c], c == 3 || c == 8); end
        end
        checks++; if (wd_log[7] !== 32'hBBBB0002) begin errors++; $display("FAIL b2b_wdata got %h expected BBBB0002", wd_log[7]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_catch_all();
        test_unmapped();
        test_timeout();
        test_busy_release();
        test_abort();
        test_back_to_back();
        test_reset_rdwait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end
endmodule
